// File: rtl/control_unit.sv
// Hardwired control sequencer for a multi-cycle datapath: fetch in T0-T2, opcode-driven
// execute in T3-T7, with a sticky HALT state left only through reset_n.
module control_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] ir,
    input  logic        stop,
    output logic        run,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        R15ctrl,
    output logic        PCout,
    output logic        MDRout,
    output logic        ZLowout,
    output logic        ZHighout,
    output logic        HIout,
    output logic        LOout,
    output logic        InPortout,
    output logic        Cout,
    output logic        PCin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        MARin,
    output logic        MDRin,
    output logic        HIin,
    output logic        LOin,
    output logic        conIn,
    output logic        outPortin,
    output logic        MDRread,
    output logic        memWrite,
    output logic        IncPC,
    output logic        conOut,
    output logic [3:0]  ALUselect
);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_JAL  = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10101;
    localparam logic [4:0] OP_OUT  = 5'b10110;
    localparam logic [4:0] OP_MFHI = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_NONE = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0110;
    localparam logic [3:0] ALU_OR   = 4'b0111;
    localparam logic [3:0] ALU_INC  = 4'b1001;

    state_t     state_q, state_d;
    state_t     last_state;
    logic [4:0] opcode;

    assign opcode = ir[31:27];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_RST;
        else          state_q <= state_d;
    end

    // Final execute step per opcode; undefined opcodes behave as a 4-cycle nop.
    always_comb begin
        last_state = S_T3;
        case (opcode)
            OP_LD, OP_ST:                      last_state = S_T7;
            OP_BR:                             last_state = S_T6;
            OP_LDI, OP_ADDI, OP_ANDI, OP_ORI:  last_state = S_T5;
            OP_JAL:                            last_state = S_T4;
            default:                           last_state = S_T3;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:  state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_HALT: state_d = S_HALT;
            default: begin
                if (state_q == S_T3 && opcode == OP_HALT)
                    state_d = S_HALT;
                else if (state_q == last_state || state_q == S_T7)
                    state_d = stop ? S_HALT : S_T0;
                else
                    state_d = state_t'(state_q + 4'd1);
            end
        endcase
    end

    always_comb begin
        run = 1'b1;
        {Gra, Grb, Grc, Rin, Rout, BAout, R15ctrl} = '0;
        {PCout, MDRout, ZLowout, ZHighout, HIout, LOout, InPortout, Cout} = '0;
        {PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin, conIn, outPortin} = '0;
        {MDRread, memWrite, IncPC, conOut} = '0;
        ALUselect = ALU_NONE;
        case (state_q)
            S_HALT: run = 1'b0;
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                ALUselect = ALU_INC;
            end
            S_T1: begin
                ZLowout = 1'b1; PCin = 1'b1; MDRread = 1'b1; MDRin = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
                case (opcode)
                    OP_LD, OP_LDI, OP_ST: begin
                        Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                    end
                    OP_ADDI, OP_ANDI, OP_ORI: begin
                        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    end
                    OP_BR:   begin Gra = 1'b1; Rout = 1'b1; conIn = 1'b1; end
                    OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    OP_JAL:  begin R15ctrl = 1'b1; PCout = 1'b1; end
                    OP_IN:   begin Gra = 1'b1; Rin = 1'b1; InPortout = 1'b1; end
                    OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; outPortin = 1'b1; end
                    OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                case (opcode)
                    OP_LD, OP_LDI, OP_ST: begin
                        Cout = 1'b1; Zin = 1'b1; ALUselect = ALU_ADD;
                    end
                    OP_ADDI: begin Cout = 1'b1; Zin = 1'b1; ALUselect = ALU_ADD; end
                    OP_ANDI: begin Cout = 1'b1; Zin = 1'b1; ALUselect = ALU_AND; end
                    OP_ORI:  begin Cout = 1'b1; Zin = 1'b1; ALUselect = ALU_OR;  end
                    OP_BR:   begin PCout = 1'b1; Yin = 1'b1; end
                    OP_JAL:  begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                case (opcode)
                    OP_LD, OP_ST: begin ZLowout = 1'b1; MARin = 1'b1; end
                    OP_LDI, OP_ADDI, OP_ANDI, OP_ORI: begin
                        ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    OP_BR: begin Cout = 1'b1; Zin = 1'b1; ALUselect = ALU_ADD; end
                    default: ;
                endcase
            end
            S_T6: begin
                case (opcode)
                    OP_LD: begin MDRread = 1'b1; MDRin = 1'b1; end
                    OP_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                    OP_BR: begin ZLowout = 1'b1; conOut = 1'b1; end
                    default: ;
                endcase
            end
            S_T7: begin
                case (opcode)
                    OP_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_ST: begin MDRout = 1'b1; memWrite = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle control vectors from a table plus
// hand sequences for async reset, stop-to-HALT and bus-driver exclusivity.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] ir = 32'h0;
    logic        stop = 1'b0;

    logic run, Gra, Grb, Grc, Rin, Rout, BAout, R15ctrl;
    logic PCout, MDRout, ZLowout, ZHighout, HIout, LOout, InPortout, Cout;
    logic PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin, conIn, outPortin;
    logic MDRread, memWrite, IncPC, conOut;
    logic [3:0] ALUselect;

    control_unit dut (
        .clk(clk), .reset_n(reset_n), .ir(ir), .stop(stop), .run(run),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .R15ctrl(R15ctrl), .PCout(PCout), .MDRout(MDRout), .ZLowout(ZLowout),
        .ZHighout(ZHighout), .HIout(HIout), .LOout(LOout), .InPortout(InPortout),
        .Cout(Cout), .PCin(PCin), .IRin(IRin), .Yin(Yin), .Zin(Zin), .MARin(MARin),
        .MDRin(MDRin), .HIin(HIin), .LOin(LOin), .conIn(conIn), .outPortin(outPortin),
        .MDRread(MDRread), .memWrite(memWrite), .IncPC(IncPC), .conOut(conOut),
        .ALUselect(ALUselect)
    );

    always #5 clk = ~clk;

    logic [33:0] obs;
    assign obs = {run, Gra, Grb, Grc, Rin, Rout, BAout, R15ctrl,
                  PCout, MDRout, ZLowout, ZHighout, HIout, LOout, InPortout, Cout,
                  PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin, conIn, outPortin,
                  MDRread, memWrite, IncPC, conOut, ALUselect};

    localparam logic [33:0] B1 = 34'd1;
    localparam logic [33:0] RUN = B1 << 33, GRA = B1 << 32, GRB = B1 << 31;
    localparam logic [33:0] RIN = B1 << 29, ROUT = B1 << 28, BAOUT = B1 << 27, R15 = B1 << 26;
    localparam logic [33:0] PCOUT = B1 << 25, MDROUT = B1 << 24, ZLOW = B1 << 23;
    localparam logic [33:0] HIOUT = B1 << 21, LOOUT = B1 << 20, INPORT = B1 << 19, COUT = B1 << 18;
    localparam logic [33:0] PCIN = B1 << 17, IRIN = B1 << 16, YIN = B1 << 15, ZIN = B1 << 14;
    localparam logic [33:0] MARIN = B1 << 13, MDRIN = B1 << 12, CONIN = B1 << 9, OUTPIN = B1 << 8;
    localparam logic [33:0] MDRRD = B1 << 7, MEMWR = B1 << 6, INCPC = B1 << 5, CONOUT = B1 << 4;
    localparam logic [33:0] A_ADD = 34'd1, A_AND = 34'd6, A_OR = 34'd7, A_INC = 34'd9;

    localparam logic [33:0] E_T0 = RUN | PCOUT | MARIN | INCPC | ZIN | A_INC;
    localparam logic [33:0] E_T1 = RUN | ZLOW | PCIN | MDRRD | MDRIN;
    localparam logic [33:0] E_T2 = RUN | MDROUT | IRIN;

    typedef struct {
        logic [31:0] ir;
        int          k;
        logic [33:0] exp;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int failures = 0;
    int excl_err = 0;

    // Bus-driver exclusivity watched on every falling edge for the whole run.
    always @(negedge clk) begin
        if ($countones({PCout, MDRout, ZLowout, ZHighout, HIout, LOout,
                        InPortout, Cout, Rout}) > 1)
            excl_err++;
    end

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in T0 of an instruction fetching `op`, sampled 1 after the edge.
    task automatic start_instr(input logic [31:0] op);
        ir = op;
        stop = 1'b0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic add(input logic [31:0] op, input int k, input logic [33:0] exp);
        vecs.push_back('{op, k, exp});
    endtask

    initial begin
        // ld
        add(32'h00800055, 0, E_T0);
        add(32'h00800055, 1, E_T1);
        add(32'h00800055, 2, E_T2);
        add(32'h00800055, 3, RUN | GRB | BAOUT | YIN);
        add(32'h00800055, 4, RUN | COUT | ZIN | A_ADD);
        add(32'h00800055, 5, RUN | ZLOW | MARIN);
        add(32'h00800055, 6, RUN | MDRRD | MDRIN);
        add(32'h00800055, 7, RUN | MDROUT | GRA | RIN);
        add(32'h00800055, 8, E_T0);
        // ldi, st
        add(32'h08000000, 5, RUN | ZLOW | GRA | RIN);
        add(32'h08000000, 6, E_T0);
        add(32'h10000000, 6, RUN | GRA | ROUT | MDRIN);
        add(32'h10000000, 7, RUN | MDROUT | MEMWR);
        add(32'h10000000, 8, E_T0);
        // addi, andi, ori
        add(32'h590FFFFB, 3, RUN | GRB | ROUT | YIN);
        add(32'h590FFFFB, 4, RUN | COUT | ZIN | A_ADD);
        add(32'h590FFFFB, 5, RUN | ZLOW | GRA | RIN);
        add(32'h590FFFFB, 6, E_T0);
        add(32'h6108001A, 4, RUN | COUT | ZIN | A_AND);
        add(32'h6108001A, 6, E_T0);
        add(32'h68000000, 4, RUN | COUT | ZIN | A_OR);
        // branch
        add(32'h91000023, 3, RUN | GRA | ROUT | CONIN);
        add(32'h91000023, 4, RUN | PCOUT | YIN);
        add(32'h91000023, 5, RUN | COUT | ZIN | A_ADD);
        add(32'h91000023, 6, RUN | ZLOW | CONOUT);
        add(32'h91000023, 7, E_T0);
        // jr, jal
        add(32'h98000000, 3, RUN | GRA | ROUT | PCIN);
        add(32'h98000000, 4, E_T0);
        add(32'hA0800000, 3, RUN | R15 | PCOUT);
        add(32'hA0800000, 4, RUN | GRA | ROUT | PCIN);
        add(32'hA0800000, 5, E_T0);
        // in, out, mfhi, mflo, nop, undefined
        add(32'hA8000000, 3, RUN | GRA | RIN | INPORT);
        add(32'hB0000000, 3, RUN | GRA | ROUT | OUTPIN);
        add(32'hB8000000, 3, RUN | HIOUT | GRA | RIN);
        add(32'hC0000000, 3, RUN | LOOUT | GRA | RIN);
        add(32'hC0000000, 4, E_T0);
        add(32'hD0000000, 3, RUN);
        add(32'hD0000000, 4, E_T0);
        add(32'hF8000000, 3, RUN);
        add(32'hF8000000, 4, E_T0);
        // halt
        add(32'hD8000000, 3, RUN);
        add(32'hD8000000, 4, 34'd0);

        // Reset state
        reset_n = 1'b0;
        #2;
        check("rst_state", obs, RUN);
        step();
        check("rst_held", obs, RUN);

        foreach (vecs[i]) begin
            start_instr(vecs[i].ir);
            repeat (vecs[i].k) step();
            check($sformatf("vec%0d ir=%h k=%0d", i, vecs[i].ir, vecs[i].k), obs, vecs[i].exp);
        end

        // Asynchronous reset in the middle of ld T5, then release into T0
        start_instr(32'h00800055);
        repeat (5) step();
        check("ld_t5_before_rst", obs, RUN | ZLOW | MARIN);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_mid_cycle", obs, RUN);
        #2;
        reset_n = 1'b1;
        step();
        check("rst_release_t0", obs, E_T0);

        // Halt stays quiet for 20 cycles after entering HALT
        start_instr(32'hD8000000);
        repeat (4) step();
        for (int c = 0; c < 20; c++) begin
            check($sformatf("halt_idle_c%0d", c), obs, 34'd0);
            step();
        end

        // stop raised in ld T4 lets ld finish, then HALT
        start_instr(32'h00800055);
        repeat (4) step();
        stop = 1'b1;
        step();
        check("stop_ld_t5", obs, RUN | ZLOW | MARIN);
        step();
        check("stop_ld_t6", obs, RUN | MDRRD | MDRIN);
        step();
        check("stop_ld_t7", obs, RUN | MDROUT | GRA | RIN);
        step();
        check("stop_halt", obs, 34'd0);
        stop = 1'b0;
        repeat (3) step();
        check("stop_halt_sticky", obs, 34'd0);

        // stop=1 across fetch of a nop still only halts at the boundary
        start_instr(32'hD0000000);
        stop = 1'b1;
        step();
        check("stop_nop_t1", obs, E_T1);
        repeat (2) step();
        check("stop_nop_t3", obs, RUN);
        step();
        check("stop_nop_halt", obs, 34'd0);

        checks++;
        if (excl_err != 0) begin
            failures++;
            $display("FAIL bus_exclusive got=%0d violations exp=0", excl_err);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Port: clk  in  1  system clock; all state changes on the rising edge.
REQ-003 Port: reset_n  in  1  asynchronous active-low reset.
REQ-004 Port: ir  in  32  instruction register contents; opcode is ir[31:27].
REQ-005 Port: stop  in  1  halt request, sampled at instruction boundaries.
REQ-006 Port: run  out  1  high while sequencing; low in HALT.
REQ-007 Ports: Gra, Grb, Grc, Rin, Rout, BAout, R15ctrl  out  1 each  register-file select/strobe controls.
REQ-008 Ports: PCout, MDRout, ZLowout, ZHighout, HIout, LOout, InPortout, Cout  out  1 each  bus-driver enables.
REQ-009 Ports: PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin, conIn, outPortin  out  1 each  register load enables.
REQ-010 Ports: MDRread, memWrite, IncPC, conOut  out  1 each  memory read-select, memory write, PC increment, conditional PC load.
REQ-011 Port: ALUselect  out  4  ALU op: 0000 none, 0001 add, 0110 and, 0111 or, 1001 PC increment.

Function
REQ-012 State register SHALL hold one of RST, T0..T7, HALT; one state per clock cycle.
REQ-013 Outputs SHALL be a combinational decode of the state register and ir[31:27]; any control not listed for a state is 0.
REQ-014 RST->T0 on the first rising edge with reset_n high.
REQ-015 T0: PCout, MARin, IncPC, Zin, ALUselect=1001. T1: ZLowout, PCin, MDRread, MDRin. T2: MDRout, IRin. Decode starts in T3 (ir valid).
REQ-016 ld (00000): T3 Grb,BAout,Yin; T4 Cout,ALUselect=0001,Zin; T5 ZLowout,MARin; T6 MDRread,MDRin; T7 MDRout,Gra,Rin.
REQ-017 ldi (00001): T3,T4 as ld; T5 ZLowout,Gra,Rin.
REQ-018 st (00010): T3-T5 as ld; T6 Gra,Rout,MDRin (MDRread=0); T7 MDRout,memWrite.
REQ-019 addi/andi/ori (01011/01100/01101): T3 Grb,Rout,Yin; T4 Cout,Zin,ALUselect=0001/0110/0111; T5 ZLowout,Gra,Rin.
REQ-020 branch (10010): T3 Gra,Rout,conIn; T4 PCout,Yin; T5 Cout,ALUselect=0001,Zin; T6 ZLowout,conOut.
REQ-021 jr (10011): T3 Gra,Rout,PCin. jal (10100): T3 R15ctrl,PCout; T4 Gra,Rout,PCin.
REQ-022 in (10101): T3 Gra,Rin,InPortout. out (10110): T3 Gra,Rout,outPortin.
REQ-023 mfhi (10111): T3 HIout,Gra,Rin. mflo (11000): T3 LOout,Gra,Rin.
REQ-024 nop (11010) and every undefined opcode: T3 with no controls asserted.
REQ-025 The final state of each instruction SHALL transition to T0, or to HALT if stop=1 at that edge.
REQ-026 Instruction length in cycles: ld/st 8, branch 7, ldi/addi/andi/ori 6, jal 5, all others 4.
REQ-027 halt (11011): T3 asserts no controls, then HALT; HALT is sticky (no controls, run=0) until reset_n is low.
REQ-028 At most one bus-driver enable (REQ-008 group, plus Rout) SHALL be high in any state.
REQ-029 stop asserted mid-instruction SHALL NOT abort it; the instruction completes first.

Reset
REQ-030 reset_n low SHALL force RST immediately, independent of clk, abandoning any instruction in progress.
REQ-031 In RST all outputs SHALL be 0 except run=1; ALUselect=0000.

Verification
REQ-032 reset_n low during T5 of ld -> all strobes 0 without waiting for a clock edge; release -> T0 on the next rising edge.
REQ-033 ir=0x00800055 (ld) -> MARin high in T0 and T5, MDRread high in T1 and T6, MDRout+Gra+Rin in T7; next T0 at cycle 8.
REQ-034 ir=0x590FFFFB (addi) -> ALUselect=0001 in T4; ir=0x6108001A (andi) -> 0110; both return to T0 after 6 cycles.
REQ-035 ir=0x91000023 (branch) -> conIn in T3, conOut in T6, 7 cycles; ir=0xA0800000 (jal) -> R15ctrl+PCout in T3, PCin in T4.
REQ-036 ir=0xD8000000 (halt) -> run=0 from cycle 4, no strobes for 20 cycles; stop=1 raised during ld T4 -> ld completes T7, then HALT.
REQ-037 ir=0xF8000000 (undefined opcode) -> 4-cycle nop with Rin, memWrite and PCin (outside T1) never asserted; checker confirms REQ-028 on every cycle.
